// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS operand-fetch slice.
// Optional macro MIPS_OPF_BYPASS_EN (used by the top) enables write-first bypass and stall refresh.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_operand_fetch_if.sv
// Issue, hazard-control, writeback and operand bus between the decoder and the operand-fetch stage.
interface mips_operand_fetch_if;
  import mips_pkg::*;

  logic              iss_valid;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [15:0]       imm;
  logic              use_imm;
  logic              stall;
  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              op_valid;

  modport master (
    output iss_valid, rs_addr, rt_addr, imm, use_imm, stall, flush,
    output wr_en, wr_addr, wr_data,
    input  a_out, b_out, op_valid
  );

  modport slave (
    input  iss_valid, rs_addr, rt_addr, imm, use_imm, stall, flush,
    input  wr_en, wr_addr, wr_data,
    output a_out, b_out, op_valid
  );

endinterface

// File: rtl/mips_regfile.sv
// 32 x 32-bit general register file: two combinational read ports, one write port.
// Register 0 is hardwired to zero on read and never written.
module mips_regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data
);

  logic [DATA_W-1:0] regs_r [0:NREG-1];

  // Register storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en && (wr_addr != REG_ZERO)) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  assign rd_a_data = (rd_a_addr == REG_ZERO) ? {DATA_W{1'b0}} : regs_r[rd_a_addr];
  assign rd_b_data = (rd_b_addr == REG_ZERO) ? {DATA_W{1'b0}} : regs_r[rd_b_addr];

endmodule

// File: rtl/mips_operand_fetch.sv
// Operand-fetch stage: register file plus registered ALU operand latch with stall/flush.
// Define MIPS_OPF_BYPASS_EN for write-first collision bypass and refresh of stalled operands.
module mips_operand_fetch
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  mips_operand_fetch_if.slave  bus
);

  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;
  logic [DATA_W-1:0] a_cap_s;
  logic [DATA_W-1:0] b_cap_s;
  logic [DATA_W-1:0] a_nxt_s;
  logic [DATA_W-1:0] b_nxt_s;
  logic              v_nxt_s;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              v_r;
  logic              wr_hit_s;

`ifdef MIPS_OPF_BYPASS_EN
  logic [ADDR_W-1:0] rs_r;
  logic [ADDR_W-1:0] rt_r;
  logic              use_imm_r;
`endif

  mips_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .rd_a_addr (bus.rs_addr),
    .rd_b_addr (bus.rt_addr),
    .rd_a_data (rd_a_s),
    .rd_b_data (rd_b_s)
  );

  assign wr_hit_s = bus.wr_en && (bus.wr_addr != REG_ZERO);

  // Operand values that an issue this cycle would capture
  always_comb begin
    a_cap_s = rd_a_s;
    b_cap_s = rd_b_s;
`ifdef MIPS_OPF_BYPASS_EN
    if (wr_hit_s && (bus.wr_addr == bus.rs_addr)) begin
      a_cap_s = bus.wr_data;
    end else begin
      a_cap_s = rd_a_s;
    end
    if (bus.use_imm) begin
      b_cap_s = sext16(bus.imm);
    end else if (wr_hit_s && (bus.wr_addr == bus.rt_addr)) begin
      b_cap_s = bus.wr_data;
    end else begin
      b_cap_s = rd_b_s;
    end
`else
    if (bus.use_imm) begin
      b_cap_s = sext16(bus.imm);
    end else begin
      b_cap_s = rd_b_s;
    end
`endif
  end

  // Output latch next state: flush > stall > issue > idle
  always_comb begin
    a_nxt_s = a_r;
    b_nxt_s = b_r;
    v_nxt_s = 1'b0;
    if (bus.flush) begin
      v_nxt_s = 1'b0;
    end else if (bus.stall) begin
      v_nxt_s = v_r;
`ifdef MIPS_OPF_BYPASS_EN
      if (wr_hit_s && (bus.wr_addr == rs_r)) begin
        a_nxt_s = bus.wr_data;
      end else begin
        a_nxt_s = a_r;
      end
      if (wr_hit_s && !use_imm_r && (bus.wr_addr == rt_r)) begin
        b_nxt_s = bus.wr_data;
      end else begin
        b_nxt_s = b_r;
      end
`endif
    end else if (bus.iss_valid) begin
      a_nxt_s = a_cap_s;
      b_nxt_s = b_cap_s;
      v_nxt_s = 1'b1;
    end else begin
      v_nxt_s = 1'b0;
    end
  end

  // Registered operand outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= {DATA_W{1'b0}};
      b_r <= {DATA_W{1'b0}};
      v_r <= 1'b0;
    end else begin
      a_r <= a_nxt_s;
      b_r <= b_nxt_s;
      v_r <= v_nxt_s;
    end
  end

`ifdef MIPS_OPF_BYPASS_EN
  // Source addresses of the operand pair currently held, used to refresh it while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_r      <= {ADDR_W{1'b0}};
      rt_r      <= {ADDR_W{1'b0}};
      use_imm_r <= 1'b0;
    end else if (!bus.flush && !bus.stall && bus.iss_valid) begin
      rs_r      <= bus.rs_addr;
      rt_r      <= bus.rt_addr;
      use_imm_r <= bus.use_imm;
    end
  end
`endif

  assign bus.a_out    = a_r;
  assign bus.b_out    = b_r;
  assign bus.op_valid = v_r;

endmodule

// File: tb/tb_mips_operand_fetch.sv
// Directed scoreboard bench for mips_operand_fetch; expectations follow MIPS_OPF_BYPASS_EN.
module tb_mips_operand_fetch;

`ifdef MIPS_OPF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  mips_operand_fetch_if bus();

  mips_operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] ea, input logic [31:0] eb, input logic ev);
    exp_t e;
    e.a = ea;
    e.b = eb;
    e.v = ev;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_a"}, bus.a_out, e.a);
      chk({tag, "_b"}, bus.b_out, e.b);
      chk({tag, "_v"}, {31'd0, bus.op_valid}, {31'd0, e.v});
    end
  endtask

  task automatic drive(input logic iss, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [15:0] imm, input logic ui, input logic st, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus.iss_valid = iss;
    bus.rs_addr   = rs;
    bus.rt_addr   = rt;
    bus.imm       = imm;
    bus.use_imm   = ui;
    bus.stall     = st;
    bus.flush     = fl;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
  endtask

  // Expectation is queued now, compared at the falling edge after the next rising edge
  task automatic cycle(input string tag, input logic [31:0] ea, input logic [31:0] eb, input logic ev);
    push(ea, eb, ev);
    @(negedge clk);
    pop_check(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    push(32'h0, 32'h0, 1'b0);
    pop_check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
    cycle("wr_r5", 32'h0, 32'h0, 1'b0);
    drive(1'b1, 5'd5, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("iss_r5", 32'h1234_5678, 32'h0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("idle", 32'h1234_5678, 32'h0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    cycle("wr_r0", 32'h1234_5678, 32'h0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("rd_r0", 32'h0, 32'h0, 1'b1);

    drive(1'b1, 5'd7, 5'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hAAAA_0001);
    cycle("collide", BYP ? 32'hAAAA_0001 : 32'h0, BYP ? 32'hAAAA_0001 : 32'h0, 1'b1);
    drive(1'b1, 5'd7, 5'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("iss_r7_r5", 32'hAAAA_0001, 32'h1234_5678, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0011);
    cycle("wr_r3", 32'hAAAA_0001, 32'h1234_5678, 1'b0);
    drive(1'b1, 5'd5, 5'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("iss_r5_r3", 32'h1234_5678, 32'h0000_0011, 1'b1);

    drive(1'b1, 5'd7, 5'd7, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("stall1", 32'h1234_5678, 32'h0000_0011, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0055);
    cycle("stall_wr", 32'h1234_5678, BYP ? 32'h0000_0055 : 32'h0000_0011, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("stall3", 32'h1234_5678, BYP ? 32'h0000_0055 : 32'h0000_0011, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("unstall", 32'h1234_5678, BYP ? 32'h0000_0055 : 32'h0000_0011, 1'b0);

    drive(1'b1, 5'd5, 5'd3, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("imm_neg", 32'h1234_5678, 32'hFFFF_8000, 1'b1);
    drive(1'b1, 5'd3, 5'd3, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("imm_pos", 32'h0000_0055, 32'h0000_7FFF, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0066);
    cycle("stall_imm_wr", BYP ? 32'h0000_0066 : 32'h0000_0055, 32'h0000_7FFF, 1'b1);
    drive(1'b1, 5'd5, 5'd5, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    cycle("flush_stall", BYP ? 32'h0000_0066 : 32'h0000_0055, 32'h0000_7FFF, 1'b0);

    drive(1'b1, 5'd5, 5'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("iss_r5_r7", 32'h1234_5678, 32'hAAAA_0001, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0099);
    #1;
    rst_n = 1'b0;
    #1;
    push(32'h0, 32'h0, 1'b0);
    pop_check("async_rst");
    #1;
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 5'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("post_rst", 32'h0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
